mux4_scan_ctrl: RTL
===================

// Module: mux4_scan_ctrl
// PURPOSE
//   Upstream sequencer for the 4:1 enable-high mux. Drives the mux select S and
//   enable E to step through channels 0..3, holding each for a programmable dwell.
//   It samples the mux output Y on the last dwell cycle of each channel and
//   publishes the four samples as one word Sample[3:0] with a one-cycle Valid pulse.
//   Sweeps run once (single-shot) or back-to-back (continuous).
// PARAMETERS
//   DWELL_W  8  width of Dwell input and internal dwell counter
// PORTS
//   CLK         in   1        system clock, rising edge
//   RST         in   1        asynchronous, active-high reset
//   Start       in   1        start a sweep; sampled only in IDLE
//   Stop        in   1        abort the active sweep / stop continuous mode
//   Continuous  in   1        1: restart immediately after each sweep
//   Dwell       in   DWELL_W  cycles per channel minus 1 (0 => 1 cycle/channel)
//   Y           in   1        mux output (combinational from S/E/I)
//   S           out  2        mux select
//   E           out  1        mux enable (1 only while sweeping)
//   Busy        out  1        1 while state RUN
//   Sample      out  4        last completed sweep; bit n = Y sampled on channel n
//   Valid       out  1        one-cycle pulse when Sample updates
// BEHAVIOUR
//   Reset (async, any time): state=IDLE, S=0, E=0, Busy=0, Sample=0, Valid=0,
//     dwell cnt=0, shadow=0, latched dwell=0. Sweep in progress is discarded.
//   States: IDLE, RUN. Outputs are registered; E==Busy==(state==RUN).
//   IDLE: E=0, S=0. At an edge with Start=1 and Stop=0: DwL<=Dwell, cnt<=0,
//     S<=0, state<=RUN. Start=1 with Stop=1 in IDLE: stays IDLE (Stop wins).
//   RUN, each edge, priority order:
//     1) Stop=1: state<=IDLE, E<=0, S<=0, cnt<=0; Sample unchanged, no Valid.
//     2) cnt!=DwL: cnt<=cnt+1.
//     3) cnt==DwL: shadow[S]<=Y, cnt<=0;
//        S<3: S<=S+1;
//        S==3: Sample<={Y,shadow[2:0]}, Valid<=1 next cycle; S<=0;
//          Continuous=1: stay RUN, DwL<=Dwell (re-latched each sweep);
//          Continuous=0: state<=IDLE, E<=0.
//   Start is ignored while RUN. Dwell changes mid-sweep have no effect.
//   Timing: each channel is held for DwL+1 cycles; a sweep takes 4*(DwL+1)
//     cycles from the first RUN cycle. Valid is high for exactly 1 cycle,
//     in the cycle following the capturing edge of channel 3.
//   Continuous: no idle gap between sweeps; channel 0 of the next sweep
//     begins in the same cycle that Valid is high.
//   Y is sampled at the clock edge ending the channel's last dwell cycle, so
//     the combinational mux path has at least one full cycle to settle.
//   cnt is DWELL_W bits; DwL=all-ones is legal (2^DWELL_W cycles/channel).
// TESTING
//   T1 I=4'b1010, Dwell=0, Continuous=0, 1-cycle Start: S=0,1,2,3 on
//      consecutive cycles; Valid 1 cycle after 4 RUN cycles; Sample=4'b1010;
//      returns to IDLE, E=0.
//   T2 I=4'b0110, Dwell=3: each S value held for exactly 4 cycles; Valid after
//      16 RUN cycles; Sample=4'b0110.
//   T3 Continuous=1, Dwell=1, I=4'b1111 then 4'b0001 between sweeps: Valid
//      every 8 cycles; Sample=4'b1111 then 4'b0001; E stays 1 throughout.
//   T4 Stop during channel 2 of a sweep with Sample=4'b0101 from a prior sweep:
//      next edge IDLE, E=0, S=0, no Valid, Sample stays 4'b0101.
//   T5 RST asserted asynchronously mid-RUN (between edges): S, E, Busy,
//      Sample and Valid clear immediately; after release, Start runs a clean sweep.
//   T6 Start pulsed again while RUN: ignored (sweep length unchanged).
//      Start and Stop high together in IDLE: stays IDLE.

Source files
------------

// File: rtl/mux4_scan_ctrl.sv
// Sequencer that sweeps a 4:1 enable-high mux through channels 0..3, dwelling on each,
// and publishes the four sampled mux outputs as one word with a one-cycle valid pulse.
module mux4_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y,
    output logic [1:0]         s,
    output logic               e,
    output logic               busy,
    output logic [3:0]         sample,
    output logic               valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_lat;
    logic [2:0]         shadow;

    // Enable and busy come straight off the state flop, so they stay registered.
    assign e    = (state == RUN);
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 2'd0;
            cnt       <= '0;
            dwell_lat <= '0;
            shadow    <= 3'd0;
            sample    <= 4'd0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    s <= 2'd0;
                    if (start && !stop) begin
                        dwell_lat <= dwell;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                default: begin
                    if (stop) begin
                        state <= IDLE;
                        s     <= 2'd0;
                        cnt   <= '0;
                    end else if (cnt != dwell_lat) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Last dwell cycle of the channel: capture y, then advance.
                        cnt <= '0;
                        case (s)
                            2'd0: begin
                                shadow[0] <= y;
                                s         <= 2'd1;
                            end
                            2'd1: begin
                                shadow[1] <= y;
                                s         <= 2'd2;
                            end
                            2'd2: begin
                                shadow[2] <= y;
                                s         <= 2'd3;
                            end
                            default: begin
                                sample <= {y, shadow};
                                valid  <= 1'b1;
                                s      <= 2'd0;
                                if (continuous) begin
                                    dwell_lat <= dwell;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
